// File: rtl/multiplier_datapath_if.sv
// rtl/multiplier_datapath_if.sv - control strobes and register views between multiplier FSM and datapath
interface multiplier_datapath_if #(
    parameter int W = 8
);
    logic [W-1:0] SW;
    logic         Shift;
    logic         Add;
    logic         Sub;
    logic         Clr;
    logic         LoadB;
    logic [W-1:0] Aval;
    logic [W-1:0] Bval;
    logic         Xval;
    logic         M_val;

    // Control side drives strobes and switch value, observes registers.
    modport master (
        output SW, Shift, Add, Sub, Clr, LoadB,
        input  Aval, Bval, Xval, M_val
    );

    // Datapath side.
    modport slave (
        input  SW, Shift, Add, Sub, Clr, LoadB,
        output Aval, Bval, Xval, M_val
    );
endinterface

// File: rtl/multiplier_datapath.sv
// rtl/multiplier_datapath.sv - X/A/B registers and 9-bit add/sub for the signed add-shift multiplier
module multiplier_datapath #(
    parameter int W = 8
) (
    input  logic                   Clk,
    input  logic                   Reset_Load_Clr,
    multiplier_datapath_if.slave   bus
);
    logic         x_reg;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;

    logic         m_bit;
    logic         add_e;
    logic         sub_e;
    logic [W:0]   s9;
    logic [W:0]   a9;
    logic [W:0]   sum9;
    logic         x_n;
    logic [W-1:0] a_n;

    assign m_bit = b_reg[0];

    // Add/sub only when the current multiplier bit is set; Sub wins if both asserted.
    always_comb begin
        add_e = bus.Add & m_bit;
        sub_e = bus.Sub & m_bit;
        s9    = {bus.SW[W-1], bus.SW};
        a9    = {a_reg[W-1], a_reg};
        sum9  = {x_reg, a_reg};
        if (sub_e) begin
            sum9 = a9 + ~s9 + {{W{1'b0}}, 1'b1};
        end else if (add_e) begin
            sum9 = a9 + s9;
        end
        x_n = sum9[W];
        a_n = sum9[W-1:0];
    end

    always_ff @(posedge Clk) begin
        if (Reset_Load_Clr) begin
            x_reg <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
        end else if (bus.Clr || bus.LoadB) begin
            // Clear and load are independent; either one suppresses arithmetic/shift.
            if (bus.Clr) begin
                x_reg <= 1'b0;
                a_reg <= '0;
            end
            if (bus.LoadB) begin
                b_reg <= bus.SW;
            end
        end else if (bus.Shift) begin
            // Arithmetic right shift of {X,A,B} using the freshly computed sum.
            x_reg <= x_n;
            a_reg <= {x_n, a_n[W-1:1]};
            b_reg <= {a_n[0], b_reg[W-1:1]};
        end else if (add_e || sub_e) begin
            x_reg <= x_n;
            a_reg <= a_n;
        end
    end

    assign bus.Aval  = a_reg;
    assign bus.Bval  = b_reg;
    assign bus.Xval  = x_reg;
    assign bus.M_val = m_bit;
endmodule

// File: tb/tb_multiplier_datapath.sv
// tb/tb_multiplier_datapath.sv - self-checking bench for multiplier_datapath
module tb_multiplier_datapath;
    localparam int W = 8;

    logic Clk = 1'b0;
    logic Reset_Load_Clr;
    always #5 Clk = ~Clk;

    multiplier_datapath_if #(.W(W)) bus ();

    multiplier_datapath #(.W(W)) dut (
        .Clk            (Clk),
        .Reset_Load_Clr (Reset_Load_Clr),
        .bus            (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: X, A, B as plain values.
    logic       m_x;
    logic [7:0] m_a;
    logic [7:0] m_b;

    typedef struct {
        logic [7:0]  b_init;
        logic [7:0]  s;
        logic [15:0] prod;
        logic        x;
    } mul_vec_t;

    mul_vec_t vecs[3];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: {X,A} is a 9-bit signed accumulator, {acc,B} a signed 17-bit value.
    task automatic model(input logic rst, input logic [7:0] sw,
                         input logic sh, input logic ad, input logic su,
                         input logic cl, input logic lb);
        int acc;
        int v;
        int sa;
        int ss;
        if (rst) begin
            m_x = 1'b0; m_a = 8'h00; m_b = 8'h00;
        end else if (cl || lb) begin
            if (cl) begin m_x = 1'b0; m_a = 8'h00; end
            if (lb) m_b = sw;
        end else begin
            sa  = $signed(m_a);
            ss  = $signed(sw);
            acc = int'({24'b0, m_a}) - (m_x ? 256 : 0);
            if (su && m_b[0])      acc = sa - ss;
            else if (ad && m_b[0]) acc = sa + ss;
            acc = acc & 511;
            if (acc >= 256) acc = acc - 512;
            if (sh) begin
                v   = (acc * 256 + int'({24'b0, m_b})) >>> 1;
                m_x = (acc < 0);
                m_a = v[15:8];
                m_b = v[7:0];
            end else if ((ad || su) && m_b[0]) begin
                m_x = (acc < 0);
                m_a = acc[7:0];
            end
        end
    endtask

    task automatic step(input logic rst, input logic [7:0] sw,
                        input logic sh, input logic ad, input logic su,
                        input logic cl, input logic lb, input string tag);
        Reset_Load_Clr = rst;
        bus.SW = sw; bus.Shift = sh; bus.Add = ad; bus.Sub = su;
        bus.Clr = cl; bus.LoadB = lb;
        @(posedge Clk);
        #1;
        model(rst, sw, sh, ad, su, cl, lb);
        chk({tag, ".A"}, {8'h00, bus.Aval}, {8'h00, m_a});
        chk({tag, ".B"}, {8'h00, bus.Bval}, {8'h00, m_b});
        chk({tag, ".X"}, {15'h0, bus.Xval}, {15'h0, m_x});
        chk({tag, ".M"}, {15'h0, bus.M_val}, {15'h0, m_b[0]});
    endtask

    task automatic run_mul(input logic [7:0] b, input logic [7:0] s, input string tag);
        step(1'b0, b, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {tag, ".load"});
        for (int i = 0; i < 7; i++)
            step(1'b0, s, 1'b1, m_b[0], 1'b0, 1'b0, 1'b0, {tag, ".add"});
        step(1'b0, s, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, {tag, ".sub"});
    endtask

    initial begin
        logic [15:0] p;
        int          r;

        vecs[0] = '{b_init: 8'h07, s: 8'h03, prod: 16'h0015, x: 1'b0};
        vecs[1] = '{b_init: 8'hFE, s: 8'h03, prod: 16'hFFFA, x: 1'b1};
        vecs[2] = '{b_init: 8'h80, s: 8'h80, prod: 16'h4000, x: 1'b0};

        m_x = 1'b0; m_a = 8'h00; m_b = 8'h00;
        Reset_Load_Clr = 1'b1;
        bus.SW = 8'h00; bus.Shift = 1'b0; bus.Add = 1'b0; bus.Sub = 1'b0;
        bus.Clr = 1'b0; bus.LoadB = 1'b0;

        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "init");

        // Reset from X=1, A=AB, B=CD with strobes active.
        step(1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "rs.ld");
        step(1'b0, 8'hAB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rs.add");
        step(1'b0, 8'hCD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rs.ldb");
        chk("rs.pre", {7'h0, bus.Xval, bus.Aval}, 16'h01AB);
        step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "rs.rst");
        chk("rs.post", {bus.Aval, bus.Bval}, 16'h0000);
        chk("rs.postxm", {14'h0, bus.Xval, bus.M_val}, 16'h0000);

        // LoadB then Clr.
        step(1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "lc.ld");
        chk("lc.b", {bus.Bval, 7'h0, bus.M_val}, 16'h0701);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "lc.clr");
        chk("lc.ax", {7'h0, bus.Xval, bus.Aval}, 16'h0000);

        // Table of full multiplies.
        foreach (vecs[k]) begin
            run_mul(vecs[k].b_init, vecs[k].s, $sformatf("tbl%0d", k));
            chk($sformatf("tbl%0d.prod", k), {bus.Aval, bus.Bval}, vecs[k].prod);
            chk($sformatf("tbl%0d.x", k), {15'h0, bus.Xval}, {15'h0, vecs[k].x});
        end

        // Precedence: Clr+LoadB beat Shift/Add, from X=1, A=12, B=34.
        step(1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "pr.ld");
        step(1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "pr.a1");
        step(1'b0, 8'h92, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "pr.a2");
        step(1'b0, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "pr.ldb");
        chk("pr.pre", {7'h0, bus.Xval, bus.Aval}, 16'h0112);
        step(1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "pr.all");
        chk("pr.post", {7'h0, bus.Xval, bus.Aval}, 16'h0000);
        chk("pr.postb", {8'h0, bus.Bval}, 16'h0055);

        // M_val=0 gates both Add and Sub; shift only.
        step(1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "g0.ld");
        step(1'b0, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "g0.add");
        step(1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "g0.ldb");
        step(1'b0, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "g0.sh");
        chk("g0.res", {7'h0, bus.Xval, bus.Aval}, 16'h0008);
        chk("g0.resb", {8'h0, bus.Bval}, 16'h0001);

        // Sub wins over Add.
        step(1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "sw.ld");
        step(1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "sw.sh");
        chk("sw.res", {7'h0, bus.Xval, bus.Aval}, 16'h01FF);
        chk("sw.resb", {8'h0, bus.Bval}, 16'h0080);

        // Reset mid-multiply leaves no residue.
        step(1'b0, 8'h6B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "mr.ld");
        for (int i = 0; i < 3; i++)
            step(1'b0, 8'hC5, 1'b1, m_b[0], 1'b0, 1'b0, 1'b0, "mr.add");
        step(1'b1, 8'hC5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "mr.rst");
        chk("mr.post", {bus.Aval, bus.Bval}, 16'h0000);

        // Random full multiplies against signed product.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] rb;
            logic [7:0] rs;
            rb = 8'($urandom);
            rs = 8'($urandom);
            p  = 16'($signed(rb) * $signed(rs));
            run_mul(rb, rs, "rnd");
            chk($sformatf("rnd.prod %h*%h", rb, rs), {bus.Aval, bus.Bval}, p);
            chk("rnd.x", {15'h0, bus.Xval}, {15'h0, p[15]});
        end

        // Random strobe mix against the model.
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 31));
            step(r == 0, 8'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), "mix");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multiplier_datapath.md
Name: multiplier_datapath

Overview:
- Register and arithmetic datapath for the 8-bit signed (two's-complement) add-shift multiplier.
- Holds the sign-extension bit X, accumulator A and multiplier B, plus a 9-bit adder/subtractor with S as the second operand.
- Consumes the Shift/Add/Sub/Clr/LoadB strobes from the multiplier control FSM and returns M_val (B[0]) to it.
- After 8 shift cycles, the 16-bit product sits in {A,B}, with X equal to the product sign.

Parameters:
W, 8, operand width; A, B, S and SW are W bits wide, and the adder is W+1 bits wide.

Ports:
Clk  input  1  system clock; all state updates on its rising edge
Reset_Load_Clr  input  1  synchronous, active-high reset
SW  input  W  switch value; loaded into B on LoadB; used live as multiplicand S on Add/Sub
Shift  input  1  arithmetic right shift of {X,A,B} this cycle
Add  input  1  A += S this cycle (gated by M_val)
Sub  input  1  A -= S this cycle (gated by M_val)
Clr  input  1  clear X and A
LoadB  input  1  load B from SW
Aval  output  W  accumulator register (product high byte)
Bval  output  W  multiplier register (product low byte)
Xval  output  1  sign-extension bit
M_val  output  1  combinational copy of B[0]

Behaviour:
- Reset: when Reset_Load_Clr=1 at a rising edge, X, A and B all become 0, so M_val=0. Reset overrides every strobe and may be asserted mid-multiply; the operation is abandoned with no residue.
- Precedence, highest first: reset, then {Clr, LoadB}, then arithmetic/shift.
  - Clr and LoadB are independent of each other. Both may apply in the same cycle.
  - Clr: X=0, A=0; B is held.
  - LoadB: B=SW; X and A are held.
  - If Clr or LoadB is asserted, Shift/Add/Sub are ignored for that cycle.
- Arithmetic step (combinational, same cycle as the shift):
  - addE = Add & M_val; subE = Sub & M_val. If both Add and Sub are asserted, Sub wins.
  - S9 = {SW[W-1], SW}.
  - addE: sum9 = {A[W-1], A} + S9.
  - subE: sum9 = {A[W-1], A} + ~S9 + 1.
  - Neither: sum9 = {X, A}; X and A pass through unchanged.
  - The carry out of bit W is discarded. Xn = sum9[W], An = sum9[W-1:0].
- Register update, in a single cycle, with no idle cycle between an add and its shift:
  - Shift=1: X=Xn; A={Xn, An[W-1:1]}; B={An[0], B[W-1:1]}. This is an arithmetic right shift; X is replicated into A's MSB.
  - Shift=0 with addE/subE: X=Xn, A=An, B held.
  - All strobes low: all registers hold.
- Latency: outputs reflect each update one clock after the strobe. M_val tracks B[0] with no added delay, so the FSM always sees the bit for the current step.
- Full multiply, with B and S loaded and A, X cleared:
  - 7 cycles of Shift with Add=M_val.
  - 1 cycle of Shift with Sub (the datapath gates Sub by M_val).
  - Result: {A,B} is the signed 16-bit product of B_init and S; X equals A[W-1].
- SW must stay stable for the 8 compute cycles; a change mid-sequence is used immediately, and the result is then undefined by design.
- Back-to-back run: after Clr, the next multiply uses the current B, i.e. the previous product low byte. This is intended behaviour.
- No overflow flag. Arithmetic wraps modulo 2^(W+1) inside the 9-bit adder; this never loses bits for W-bit signed operands.

Test Plan:
- Reset with registers at X=1, A=0xAB, B=0xCD -> next cycle X=0, A=0x00, B=0x00, M_val=0.
- LoadB with SW=0x07, then Clr -> B=0x07 and M_val=1; A=0x00 and X=0 one cycle after Clr.
- B=0x07, SW=0x03, 7x(Shift, Add=M_val) then (Shift, Sub) -> A=0x00, B=0x15 (21), X=0 after exactly 8 cycles.
- B=0xFE (-2), SW=0x03, same 8-step sequence -> A=0xFF, B=0xFA (-6), X=1. Also B=0x80, SW=0x80 -> A=0x40, B=0x00 (+16384), X=0.
- Start from X=1, A=0x12, B=0x34; assert Clr, LoadB, Shift and Add together with SW=0x55 -> X=0, A=0x00, B=0x55; no shift occurs.
- B=0x02 (M_val=0), A=0x10, assert Shift with Add=1 and Sub=1 -> no arithmetic; X=0, A=0x08, B=0x01. Repeat with B=0x01, A=0x00, SW=0x01, Add=Sub=Shift=1 -> Sub wins: X=1, A=0xFF, B=0x80.
